frame_sequencer: RTL and testbench

Sequences the transfer of a completed frame from the next-target framebuffer into the target framebuffer at a driver frame boundary, so the animator never reads a half-received frame. It owns the next-target read port and the target write port, latches the frame's time/type, and pulses a start strobe to the animator. It also keeps a per-frame elapsed counter, which the animator uses as its start-time reference.

---
 rtl/frame_sequencer.sv | 140 ++++++++++++++
 tb/tb_frame_sequencer.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/frame_sequencer.sv
// frame_sequencer: copies a completed next-target frame into the target
// framebuffer at a driver latch boundary. It then pulses o_start to the animator.
// It also keeps a saturating count of latch pulses since the last commit.
module frame_sequencer #(
    parameter int c_ledboards = 30,
    parameter int c_bpc       = 12,
    parameter int c_max_time  = 1024,
    parameter int c_max_type  = 64,
    localparam int c_channels = c_ledboards * 32,
    localparam int c_time_w   = $clog2(c_max_time),
    localparam int c_type_w   = $clog2(c_max_type),
    localparam int c_addr_w   = $clog2(c_channels)
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_frame_done,
    input  logic                i_lat,
    input  logic [c_bpc-1:0]    i_next_data,
    input  logic [c_time_w-1:0] i_next_time,
    input  logic [c_type_w-1:0] i_next_type,
    output logic [c_addr_w-1:0] o_next_raddr,
    output logic                o_target_wen,
    output logic [c_addr_w-1:0] o_target_waddr,
    output logic [c_bpc-1:0]    o_target_wdata,
    output logic [c_time_w-1:0] o_target_time,
    output logic [c_type_w-1:0] o_target_type,
    output logic                o_busy,
    output logic                o_start,
    output logic [c_time_w-1:0] o_elapsed
);

    localparam logic [c_addr_w-1:0] c_last_addr   = c_addr_w'(c_channels - 1);
    localparam logic [c_time_w-1:0] c_elapsed_max = c_time_w'(c_max_time - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_COPY,
        ST_FLUSH,
        ST_DONE
    } state_t;

    state_t              state_reg;
    logic                pending_reg;
    logic [c_addr_w-1:0] raddr_reg;
    logic                wen_reg;
    logic [c_addr_w-1:0] waddr_reg;
    logic [c_time_w-1:0] time_reg;
    logic [c_type_w-1:0] type_reg;
    logic                busy_reg;
    logic                start_reg;
    logic [c_time_w-1:0] elapsed_reg;
    logic                copy_start;

    // A copy may only begin from IDLE, on a latch boundary, with a frame waiting.
    assign copy_start = (state_reg == ST_IDLE) && i_lat && pending_reg;

    // Pending frame flag; a frame_done arriving with the copy start is kept for the next copy.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            pending_reg <= 1'b0;
        end else if (copy_start) begin
            pending_reg <= i_frame_done;
        end else if (i_frame_done) begin
            pending_reg <= 1'b1;
        end
    end

    // Copy sequencer: walk read addresses, trail them with writes, then commit.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_reg <= ST_IDLE;
            raddr_reg <= '0;
            wen_reg   <= 1'b0;
            waddr_reg <= '0;
            time_reg  <= '0;
            type_reg  <= '0;
            busy_reg  <= 1'b0;
            start_reg <= 1'b0;
        end else begin
            start_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (copy_start) begin
                        time_reg  <= i_next_time;
                        type_reg  <= i_next_type;
                        raddr_reg <= '0;
                        busy_reg  <= 1'b1;
                        state_reg <= ST_COPY;
                    end
                end
                ST_COPY: begin
                    // Read data for raddr_reg arrives next cycle, so the write
                    // for this address is scheduled one cycle behind.
                    wen_reg   <= 1'b1;
                    waddr_reg <= raddr_reg;
                    if (raddr_reg == c_last_addr) begin
                        raddr_reg <= '0;
                        state_reg <= ST_FLUSH;
                    end else begin
                        raddr_reg <= raddr_reg + c_addr_w'(1);
                    end
                end
                ST_FLUSH: begin
                    // The last channel's write is on the bus this cycle.
                    wen_reg   <= 1'b0;
                    busy_reg  <= 1'b0;
                    start_reg <= 1'b1;
                    state_reg <= ST_DONE;
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    // Latch pulses since the last commit; the commit clear beats a coincident latch.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            elapsed_reg <= '0;
        end else if (start_reg) begin
            elapsed_reg <= '0;
        end else if (i_lat && (elapsed_reg != c_elapsed_max)) begin
            elapsed_reg <= elapsed_reg + c_time_w'(1);
        end
    end

    assign o_next_raddr   = raddr_reg;
    assign o_target_wen   = wen_reg;
    assign o_target_waddr = waddr_reg;
    // Read data is already one cycle behind its address, which lines it up with
    // the registered write address; it is zeroed whenever no write is in progress.
    assign o_target_wdata = wen_reg ? i_next_data : '0;
    assign o_target_time  = time_reg;
    assign o_target_type  = type_reg;
    assign o_busy         = busy_reg;
    assign o_start        = start_reg;
    assign o_elapsed      = elapsed_reg;

endmodule

// File: tb/tb_frame_sequencer.sv
// Testbench for frame_sequencer (1 LED board, 32 channels). A behavioural model
// tracks the copy as "cycles since trigger" and derives the expected outputs from that count.
module tb_frame_sequencer;

    localparam int N     = 32;
    localparam int MAXT  = 1024;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b0;
    logic        i_frame_done = 1'b0;
    logic        i_lat = 1'b0;
    logic [11:0] i_next_data = '0;
    logic [9:0]  i_next_time = '0;
    logic [5:0]  i_next_type = '0;
    logic [4:0]  o_next_raddr;
    logic        o_target_wen;
    logic [4:0]  o_target_waddr;
    logic [11:0] o_target_wdata;
    logic [9:0]  o_target_time;
    logic [5:0]  o_target_type;
    logic        o_busy;
    logic        o_start;
    logic [9:0]  o_elapsed;

    logic [11:0] next_mem [N];

    int check_cnt = 0;
    int pass_cnt  = 0;

    // model state
    int m_k       = 0;   // 0 = no copy, else cycles since the triggering latch
    bit m_pending = 0;
    int m_elapsed = 0;
    int m_time    = 0;
    int m_type    = 0;

    frame_sequencer #(.c_ledboards(1)) dut (
        .i_clk          (i_clk),
        .i_rst          (i_rst),
        .i_frame_done   (i_frame_done),
        .i_lat          (i_lat),
        .i_next_data    (i_next_data),
        .i_next_time    (i_next_time),
        .i_next_type    (i_next_type),
        .o_next_raddr   (o_next_raddr),
        .o_target_wen   (o_target_wen),
        .o_target_waddr (o_target_waddr),
        .o_target_wdata (o_target_wdata),
        .o_target_time  (o_target_time),
        .o_target_type  (o_target_type),
        .o_busy         (o_busy),
        .o_start        (o_start),
        .o_elapsed      (o_elapsed)
    );

    always #5 i_clk = ~i_clk;

    // next-target buffer with registered read
    always @(posedge i_clk) i_next_data <= next_mem[o_next_raddr];

    task automatic check_value(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        check_cnt++;
        if (actual === expected) pass_cnt++;
        else $display("FAIL %s at %0t: got %0d, expected %0d", tag, $time, actual, expected);
    endtask

    // Drive one cycle of inputs, advance the model over the clock edge, check all outputs.
    task automatic step(input bit rst, input bit done, input bit lat);
        bool_t_dummy: begin end
        i_rst = rst; i_frame_done = done; i_lat = lat;
        @(posedge i_clk);
        if (rst) begin
            m_k = 0; m_pending = 0; m_elapsed = 0; m_time = 0; m_type = 0;
        end else begin
            if (m_k == N + 2) m_elapsed = 0;
            else if (lat && m_elapsed < MAXT - 1) m_elapsed++;
            if (m_k == 0 && lat && m_pending) begin
                m_time = int'(i_next_time);
                m_type = int'(i_next_type);
                m_pending = done;
                m_k = 1;
            end else begin
                if (done) m_pending = 1;
                if (m_k != 0) m_k = (m_k == N + 2) ? 0 : m_k + 1;
            end
        end
        #1;
        check_value("busy",  32'(o_busy),  32'(m_k >= 1 && m_k <= N + 1));
        check_value("wen",   32'(o_target_wen), 32'(m_k >= 2 && m_k <= N + 1));
        check_value("start", 32'(o_start), 32'(m_k == N + 2));
        check_value("elapsed", 32'(o_elapsed), 32'(m_elapsed));
        check_value("time",  32'(o_target_time), 32'(m_time));
        check_value("type",  32'(o_target_type), 32'(m_type));
        if (m_k >= 1 && m_k <= N) check_value("raddr", 32'(o_next_raddr), 32'(m_k - 1));
        if (m_k >= 2 && m_k <= N + 1) begin
            check_value("waddr", 32'(o_target_waddr), 32'(m_k - 2));
            check_value("wdata", 32'(o_target_wdata), 32'(next_mem[m_k - 2]));
        end
        if (m_k == N + 2) $display("commit: time=%0d type=%0d at %0t", m_time, m_type, $time);
        i_rst = 1'b0; i_frame_done = 1'b0; i_lat = 1'b0;
    endtask

    task automatic run_to_idle();
        for (int i = 0; i < N + 4 && m_k != 0; i++) step(0, 0, 0);
    endtask

    initial begin
        for (int a = 0; a < N; a++) next_mem[a] = 12'(a + 5);
        i_next_time = 10'd100;
        i_next_type = 6'd3;

        // reset state
        step(1, 0, 0);
        check_value("rst_raddr", 32'(o_next_raddr), 32'd0);
        check_value("rst_waddr", 32'(o_target_waddr), 32'd0);
        check_value("rst_wdata", 32'(o_target_wdata), 32'd0);

        // latch without a frame: only elapsed moves
        step(0, 0, 1);
        check_value("idle_lat_elapsed", 32'(o_elapsed), 32'd1);
        check_value("idle_lat_busy", 32'(o_busy), 32'd0);

        // directed copy: data=addr+5, time=100, type=3
        step(0, 1, 0);
        step(0, 0, 1);
        run_to_idle();
        check_value("copy_time", 32'(o_target_time), 32'd100);
        check_value("copy_type", 32'(o_target_type), 32'd3);

        // frame_done during a copy is retained
        i_next_time = 10'd200; i_next_type = 6'd7;
        step(0, 1, 0);
        step(0, 0, 1);
        for (int i = 0; i < 4; i++) step(0, 0, 0);
        step(0, 1, 0);
        run_to_idle();
        step(0, 0, 1);
        check_value("retained_busy", 32'(o_busy), 32'd1);
        run_to_idle();

        // frame_done coincident with copy start
        step(0, 1, 0);
        step(0, 1, 1);
        check_value("coinc_busy", 32'(o_busy), 32'd1);
        run_to_idle();
        step(0, 0, 1);
        check_value("coinc_second_busy", 32'(o_busy), 32'd1);
        run_to_idle();

        // reset at copy cycle 10 aborts and drops pending
        step(0, 1, 0);
        step(0, 0, 1);
        for (int i = 0; i < N && m_k != 10; i++) step(0, 1, 0);
        step(1, 0, 0);
        check_value("abort_raddr", 32'(o_next_raddr), 32'd0);
        step(0, 0, 1);
        check_value("abort_no_copy", 32'(o_busy), 32'd0);
        for (int i = 0; i < N + 4; i++) step(0, 0, 0);

        // elapsed saturation, then commit coincident with latch
        step(1, 0, 0);
        for (int i = 0; i < 1100; i++) step(0, 0, 1);
        check_value("sat_elapsed", 32'(o_elapsed), 32'd1023);
        step(0, 1, 0);
        step(0, 0, 1);
        for (int i = 0; i < N + 4 && m_k != N + 2; i++) step(0, 0, 0);
        step(0, 0, 1);
        check_value("start_lat_clear", 32'(o_elapsed), 32'd0);
        run_to_idle();

        // randomized traffic
        for (int a = 0; a < N; a++) next_mem[a] = 12'($urandom);
        for (int i = 0; i < 3000; i++) begin
            i_next_time = 10'($urandom_range(0, MAXT - 1));
            i_next_type = 6'($urandom_range(0, 63));
            step(($urandom_range(0, 499) == 0), ($urandom_range(0, 7) == 0), ($urandom_range(0, 5) == 0));
        end

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
